hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Parametrised load/branch hazard detector for the ID stage of the forwarding pipeline; successor to the single-cycle load-use stall check.
- Keeps a registered shift pipe of in-flight register writers, covering EX and MEM_STAGES memory stages.
- Raises stall when an ID-stage source cannot be forwarded in time, and inserts a bubble into EX.
- Handles multi-cycle memory, ID-resolved branches and pipeline flush.

Parameters:
REG_AW, 5, register address width
MEM_STAGES, 1, memory-access stages after EX (1..4); a load result becomes forwardable after leaving the last one
TRACK_DEPTH, MEM_STAGES+1, tracker entries (positions 0..MEM_STAGES); derived, not overridable

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset; asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  source register 1
id_rt  in  REG_AW  source register 2
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_is_branch  in  1  instruction compares operands in ID
id_wr  in  1  instruction writes a register
id_dest  in  REG_AW  destination register
id_is_load  in  1  instruction is a memory read
flush  in  1  squash the ID instruction (taken branch / redirect)
stall  out  1  freeze PC and IF/ID
bubble  out  1  EX receives a NOP this cycle
stall_reason  out  2  0 none, 1 load-use, 2 branch-operand, 3 both

Behaviour:
- Tracker entry fields: valid, dest, is_load. Position 0 = EX, position p = memory stage p.
- Each posedge:
  - entry p moves to p+1; the entry at MEM_STAGES retires.
  - Position 0 loads {1, id_dest, id_is_load} iff id_valid && id_wr && id_dest!=0 && !stall && !flush; otherwise it loads an invalid entry.
- Ready position: r = MEM_STAGES for loads, 0 for all other writers.
- Hazard on source s (used flag set, s!=0, id_valid) against a valid entry at position p with dest==s:
  - non-branch consumer: hazard if p < r.
  - branch consumer: hazard if p <= r.
- stall, bubble and stall_reason are combinational from the tracker registers plus ID inputs; no added latency.
  - stall = any hazard && !flush; bubble = stall.
  - stall_reason bit0 = a load hazard exists; bit1 = a branch hazard on a non-load writer. A branch waiting on a load reports 1.
- Stall duration (MEM_STAGES=1):
  - load-use: 1 cycle.
  - branch after ALU op: 1 cycle.
  - branch after load: 2 cycles.
  - General load-use: MEM_STAGES - p cycles, self-terminating as the entry advances.
- flush has priority over stall: nothing enters the tracker and stall=0. Entries already in flight are kept because they are committed.
- Register 0 never hazards.
- Matches at more than one position: the hazard condition is ORed over all positions.
- Reset (async assert, sync release): all entries invalid, so stall=0, bubble=0, stall_reason=0 during and right after reset. Reset mid-stall drops the stall immediately.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs load_stall_cnt[31:0] and branch_stall_cnt[31:0].
  - Counters increment on posedge when stall is asserted with stall_reason bit0 / bit1 set respectively.
  - Both saturate at 2^32-1 and clear on rst_n.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package: REG_ZERO constant, stall_reason encodings (RSN_NONE/LOAD/BRANCH/BOTH), tracker entry struct type.
- One sub-module, pending_write_pipe: parametrised shift register of tracker entries with insert/bubble and async reset.
- Hazard compare and priority logic stays in the top module.

Test Plan:
- MEM_STAGES=1: lw r3 then add r4,r3,r5 -> stall=1, stall_reason=1 for exactly 1 cycle, bubble in EX, add issues the next cycle; no stall when r3 is replaced by r0.
- MEM_STAGES=1: add r3 then beq r3,r6 -> 1 stall cycle with reason 2. lw r3 then beq r3 -> 2 stall cycles with reason 1.
- MEM_STAGES=3: lw r7 then dependent sub -> 3 stall cycles. With one independent instruction between them -> 2 stall cycles.
- A flush raised in the first stall cycle -> stall drops the same cycle and the tracker position-0 entry is invalid on the next edge.
- rst_n asserted while stall=1 -> stall=0 immediately. After release, a dependent instruction with no prior load -> no stall.
- HAZARD_STATS_EN defined: the sequence above -> load_stall_cnt and branch_stall_cnt equal the summed stall cycles per reason. A counter forced to 0xFFFFFFFF stays saturated.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: tracker entry layout and stall reason codes.
// Tracker dest field is DEST_W wide; the top zero-extends its REG_AW-bit register numbers into it.
package hazard_scoreboard_pkg;

    localparam int DEST_W = 8;
    localparam logic [DEST_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RSN_NONE   = 2'd0,
        RSN_LOAD   = 2'd1,
        RSN_BRANCH = 2'd2,
        RSN_BOTH   = 2'd3
    } stall_reason_e;

    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic              is_load;
    } trk_entry_t;

    localparam trk_entry_t TRK_EMPTY = '{valid: 1'b0, dest: REG_ZERO, is_load: 1'b0};

endpackage

// File: rtl/pending_write_pipe.sv
// Shift pipe of in-flight register writers. Position 0 is EX; the last position retires
// on the next edge. A cleared insert enable loads an empty slot (a bubble) into position 0.
module pending_write_pipe
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ins_en_i,
    input  trk_entry_t ins_entry_i,
    output trk_entry_t pipe_o [DEPTH]
);

    trk_entry_t pipe_q [DEPTH];
    trk_entry_t pipe_d [DEPTH];

    always_comb begin
        for (int p = 0; p < DEPTH; p++) begin
            pipe_d[p] = TRK_EMPTY;
        end
        pipe_d[0] = ins_en_i ? ins_entry_i : TRK_EMPTY;
        for (int p = 1; p < DEPTH; p++) begin
            pipe_d[p] = pipe_q[p-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < DEPTH; p++) begin
                pipe_q[p] <= TRK_EMPTY;
            end
        end else begin
            for (int p = 0; p < DEPTH; p++) begin
                pipe_q[p] <= pipe_d[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < DEPTH; p++) begin
            pipe_o[p] = pipe_q[p];
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage load/branch hazard detector over EX plus MEM_STAGES memory stages.
// Optional stall statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MEM_STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              id_wr,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic              bubble,
    output logic [1:0]        stall_reason
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       load_stall_cnt,
    output logic [31:0]       branch_stall_cnt
`endif
);

    localparam int TRACK_DEPTH = MEM_STAGES + 1;

    trk_entry_t    trk [TRACK_DEPTH];
    trk_entry_t    ins_entry;
    logic          insert;
    logic          ld_haz;
    logic          br_haz;
    stall_reason_e reason;

    function automatic logic src_hit(input logic v, input logic use_s,
                                     input logic [REG_AW-1:0] s, input trk_entry_t e);
        return v && use_s && (DEST_W'(s) != REG_ZERO) && e.valid && (e.dest == DEST_W'(s));
    endfunction

    assign ins_entry = '{valid: 1'b1, dest: DEST_W'(id_dest), is_load: id_is_load};
    assign insert    = id_valid && id_wr && (DEST_W'(id_dest) != REG_ZERO) && !stall && !flush;

    pending_write_pipe #(
        .DEPTH(TRACK_DEPTH)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .ins_en_i    (insert),
        .ins_entry_i (ins_entry),
        .pipe_o      (trk)
    );

    // A load is forwardable once it leaves the last memory stage; an ALU result right after EX.
    // Branches compare in ID, so they need the value one position earlier than normal consumers.
    always_comb begin
        ld_haz = 1'b0;
        br_haz = 1'b0;
        for (int p = 0; p < TRACK_DEPTH; p++) begin
            if (src_hit(id_valid, id_use_rs, id_rs, trk[p]) ||
                src_hit(id_valid, id_use_rt, id_rt, trk[p])) begin
                if (trk[p].is_load) begin
                    if ((p < MEM_STAGES) || (id_is_branch && (p <= MEM_STAGES))) begin
                        ld_haz = 1'b1;
                    end
                end else if (id_is_branch && (p == 0)) begin
                    br_haz = 1'b1;
                end
            end
        end
    end

    always_comb begin
        reason = RSN_NONE;
        if (!flush) begin
            if (ld_haz && br_haz) begin
                reason = RSN_BOTH;
            end else if (ld_haz) begin
                reason = RSN_LOAD;
            end else if (br_haz) begin
                reason = RSN_BRANCH;
            end
        end
    end

    assign stall        = (ld_haz || br_haz) && !flush;
    assign bubble       = stall;
    assign stall_reason = reason;

`ifdef HAZARD_STATS_EN
    logic [31:0] load_cnt_q;
    logic [31:0] load_cnt_d;
    logic [31:0] branch_cnt_q;
    logic [31:0] branch_cnt_d;

    always_comb begin
        load_cnt_d   = load_cnt_q;
        branch_cnt_d = branch_cnt_q;
        if (stall && stall_reason[0] && (load_cnt_q != 32'hFFFF_FFFF)) begin
            load_cnt_d = load_cnt_q + 32'd1;
        end
        if (stall && stall_reason[1] && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q   <= '0;
            branch_cnt_q <= '0;
        end else begin
            load_cnt_q   <= load_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign load_stall_cnt   = load_cnt_q;
    assign branch_stall_cnt = branch_cnt_q;
`endif

endmodule
